// File: rtl/pc_ras.sv
// pc_ras: program counter with an integrated circular return-address stack.
// The PC supports clear, jump (load), call (push out+1 then jump), return
// (pop into PC) and increment. The stack reports its fill level and keeps
// sticky overflow/underflow flags.
//
// Ports:
//   clk        rising-edge clock
//   reset_n    asynchronous active-low reset
//   clr        synchronous clear, same end state as reset
//   in         jump or call target
//   load       jump: out <= in
//   inc        out <= out + 1
//   call       push out+1, out <= in
//   ret        pop: out <= top of stack
//   out        current PC (registered)
//   ras_count  number of valid stack entries
//   ras_full   ras_count == DEPTH
//   ras_empty  ras_count == 0
//   overflow   sticky: call made while full
//   underflow  sticky: ret made while empty
module pc_ras #(
  parameter int unsigned      WIDTH        = 16,
  parameter int unsigned      DEPTH        = 8,
  parameter logic [WIDTH-1:0] RESET_VECTOR = '0,
  parameter bit               OVERWRITE    = 1'b0,
  localparam int unsigned     CW           = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             clr,
  input  logic [WIDTH-1:0] in,
  input  logic             load,
  input  logic             inc,
  input  logic             call,
  input  logic             ret,
  output logic [WIDTH-1:0] out,
  output logic [CW-1:0]    ras_count,
  output logic             ras_full,
  output logic             ras_empty,
  output logic             overflow,
  output logic             underflow
);

  localparam int unsigned PW = $clog2(DEPTH);

  logic [WIDTH-1:0] stack [DEPTH];
  logic [PW-1:0]    top;          // next free slot
  logic [PW-1:0]    top_inc;
  logic [PW-1:0]    top_dec;
  logic [PW-1:0]    top_d;
  logic [WIDTH-1:0] pc_d;
  logic [WIDTH-1:0] ret_addr;
  logic [CW-1:0]    cnt_d;
  logic             ovf_d;
  logic             unf_d;
  logic             push;

  // Circular pointer neighbours; explicit wrap keeps non-power-of-2 depths correct.
  assign top_inc  = (top == PW'(DEPTH - 1)) ? '0 : top + PW'(1);
  assign top_dec  = (top == '0) ? PW'(DEPTH - 1) : top - PW'(1);
  assign ret_addr = out + WIDTH'(1);

  // Next-state: clr > load > call > ret > inc > hold.
  always_comb begin
    pc_d  = out;
    cnt_d = ras_count;
    top_d = top;
    ovf_d = overflow;
    unf_d = underflow;
    push  = 1'b0;
    if (clr) begin
      pc_d  = RESET_VECTOR;
      cnt_d = '0;
      top_d = '0;
      ovf_d = 1'b0;
      unf_d = 1'b0;
    end else if (load) begin
      pc_d = in;
    end else if (call) begin
      pc_d = in;
      if (!ras_full) begin
        push  = 1'b1;
        cnt_d = ras_count + CW'(1);
        top_d = top_inc;
      end else begin
        ovf_d = 1'b1;
        // When full, the slot at top holds the oldest entry, so writing it discards that entry.
        if (OVERWRITE) begin
          push  = 1'b1;
          top_d = top_inc;
        end
      end
    end else if (ret) begin
      if (ras_empty) begin
        unf_d = 1'b1;
      end else begin
        pc_d  = stack[top_dec];
        cnt_d = ras_count - CW'(1);
        top_d = top_dec;
      end
    end else if (inc) begin
      pc_d = out + WIDTH'(1);
    end
  end

  // PC, pointer and status registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      out       <= RESET_VECTOR;
      top       <= '0;
      ras_count <= '0;
      ras_full  <= 1'b0;
      ras_empty <= 1'b1;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      out       <= pc_d;
      top       <= top_d;
      ras_count <= cnt_d;
      ras_full  <= (cnt_d == CW'(DEPTH));
      ras_empty <= (cnt_d == '0);
      overflow  <= ovf_d;
      underflow <= unf_d;
    end
  end

  // Stack storage; contents after reset are don't-care.
  always_ff @(posedge clk) begin
    if (push) begin
      stack[top] <= ret_addr;
    end
  end

endmodule

// File: tb/tb_pc_ras.sv
// tb_pc_ras: self-checking bench for pc_ras. Three instances share stimulus:
//   u0: DEPTH=4, OVERWRITE=0, RESET_VECTOR=0
//   u1: DEPTH=4, OVERWRITE=1, RESET_VECTOR=0
//   u2: DEPTH=8, OVERWRITE=0, RESET_VECTOR=0x1234
// A shift-array stack model predicts every cycle; predictions are queued when
// stimulus is driven and compared by a monitor after the edge. Scenario tasks
// add directed checks against fixed constants.
module tb_pc_ras;

  typedef struct packed {
    logic [15:0] pc;
    logic [3:0]  cnt;
    logic        full;
    logic        empty;
    logic        ovf;
    logic        unf;
  } snap_t;
  typedef snap_t [2:0] snap3_t;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        clr = 1'b0, load = 1'b0, inc = 1'b0, call = 1'b0, ret = 1'b0;
  logic [15:0] in = '0;

  logic [15:0] out0, out1, out2;
  logic [2:0]  cnt0, cnt1;
  logic [3:0]  cnt2;
  logic        full0, full1, full2, empty0, empty1, empty2;
  logic        ovf0, ovf1, ovf2, unf0, unf1, unf2;

  int errors = 0;
  int checks = 0;

  snap3_t q[$];
  snap3_t act;

  // Reference model state
  int          m_dep [3] = '{4, 4, 8};
  bit          m_ow  [3] = '{1'b0, 1'b1, 1'b0};
  logic [15:0] m_rv  [3] = '{16'h0000, 16'h0000, 16'h1234};
  logic [15:0] m_pc  [3];
  int          m_cnt [3];
  logic        m_ovf [3];
  logic        m_unf [3];
  logic [15:0] m_stk [3][8];

  always #5 clk = ~clk;

  pc_ras #(.WIDTH(16), .DEPTH(4), .RESET_VECTOR(16'h0000), .OVERWRITE(1'b0)) u0 (
    .clk(clk), .reset_n(reset_n), .clr(clr), .in(in), .load(load), .inc(inc),
    .call(call), .ret(ret), .out(out0), .ras_count(cnt0), .ras_full(full0),
    .ras_empty(empty0), .overflow(ovf0), .underflow(unf0));

  pc_ras #(.WIDTH(16), .DEPTH(4), .RESET_VECTOR(16'h0000), .OVERWRITE(1'b1)) u1 (
    .clk(clk), .reset_n(reset_n), .clr(clr), .in(in), .load(load), .inc(inc),
    .call(call), .ret(ret), .out(out1), .ras_count(cnt1), .ras_full(full1),
    .ras_empty(empty1), .overflow(ovf1), .underflow(unf1));

  pc_ras #(.WIDTH(16), .DEPTH(8), .RESET_VECTOR(16'h1234), .OVERWRITE(1'b0)) u2 (
    .clk(clk), .reset_n(reset_n), .clr(clr), .in(in), .load(load), .inc(inc),
    .call(call), .ret(ret), .out(out2), .ras_count(cnt2), .ras_full(full2),
    .ras_empty(empty2), .overflow(ovf2), .underflow(unf2));

  assign act = {{out2, cnt2, full2, empty2, ovf2, unf2},
                {out1, 4'(cnt1), full1, empty1, ovf1, unf1},
                {out0, 4'(cnt0), full0, empty0, ovf0, unf0}};

  function automatic void m_reset();
    for (int i = 0; i < 3; i++) begin
      m_pc[i]  = m_rv[i];
      m_cnt[i] = 0;
      m_ovf[i] = 1'b0;
      m_unf[i] = 1'b0;
    end
  endfunction

  function automatic void m_step(input int i, input logic c_clr, c_load, c_call,
                                 c_ret, c_inc, input logic [15:0] c_in);
    logic [15:0] ra;
    if (c_clr) begin
      m_pc[i]  = m_rv[i];
      m_cnt[i] = 0;
      m_ovf[i] = 1'b0;
      m_unf[i] = 1'b0;
    end else if (c_load) begin
      m_pc[i] = c_in;
    end else if (c_call) begin
      ra = m_pc[i] + 16'd1;
      if (m_cnt[i] < m_dep[i]) begin
        m_stk[i][m_cnt[i]] = ra;
        m_cnt[i]++;
      end else begin
        m_ovf[i] = 1'b1;
        if (m_ow[i]) begin
          for (int j = 0; j < m_dep[i] - 1; j++) m_stk[i][j] = m_stk[i][j+1];
          m_stk[i][m_dep[i]-1] = ra;
        end
      end
      m_pc[i] = c_in;
    end else if (c_ret) begin
      if (m_cnt[i] == 0) begin
        m_unf[i] = 1'b1;
      end else begin
        m_cnt[i]--;
        m_pc[i] = m_stk[i][m_cnt[i]];
      end
    end else if (c_inc) begin
      m_pc[i] = m_pc[i] + 16'd1;
    end
  endfunction

  function automatic snap_t m_snap(input int i);
    snap_t s;
    s.pc    = m_pc[i];
    s.cnt   = 4'(m_cnt[i]);
    s.full  = (m_cnt[i] == m_dep[i]);
    s.empty = (m_cnt[i] == 0);
    s.ovf   = m_ovf[i];
    s.unf   = m_unf[i];
    return s;
  endfunction

  // Drive one cycle of requests, queue the prediction, return after the edge.
  task automatic drive(input logic c_clr, c_load, c_call, c_ret, c_inc,
                       input logic [15:0] c_in);
    snap3_t e;
    @(negedge clk);
    clr = c_clr; load = c_load; call = c_call; ret = c_ret; inc = c_inc; in = c_in;
    for (int i = 0; i < 3; i++) begin
      m_step(i, c_clr, c_load, c_call, c_ret, c_inc, c_in);
      e[i] = m_snap(i);
    end
    q.push_back(e);
    @(posedge clk);
    #2;
    clr = 1'b0; load = 1'b0; call = 1'b0; ret = 1'b0; inc = 1'b0;
  endtask

  // Scoreboard: compare queued predictions just after each edge.
  always @(posedge clk) begin
    snap3_t e;
    #1;
    if (q.size() > 0) begin
      e = q.pop_front();
      for (int i = 0; i < 3; i++) begin
        checks++;
        if (act[i] !== e[i]) begin
          errors++;
          $display("FAIL scoreboard u%0d t=%0t: got pc=%h cnt=%0d full=%b empty=%b ovf=%b unf=%b, expected pc=%h cnt=%0d full=%b empty=%b ovf=%b unf=%b",
                   i, $time, act[i].pc, act[i].cnt, act[i].full, act[i].empty, act[i].ovf, act[i].unf,
                   e[i].pc, e[i].cnt, e[i].full, e[i].empty, e[i].ovf, e[i].unf);
        end
      end
    end
  end

  task automatic test_reset();
    m_reset();
    #12;
    checks++;
    if (out0 !== 16'h0000 || out2 !== 16'h1234 || cnt0 !== 3'd0 || empty0 !== 1'b1 ||
        full0 !== 1'b0 || ovf0 !== 1'b0 || unf0 !== 1'b0) begin
      errors++;
      $display("FAIL reset_state: got out0=%h out2=%h cnt0=%0d empty0=%b full0=%b ovf0=%b unf0=%b, expected 0000 1234 0 1 0 0 0",
               out0, out2, cnt0, empty0, full0, ovf0, unf0);
    end
    @(negedge clk);
    reset_n = 1'b1;
    drive(0, 0, 1, 0, 0, 16'h0077);
    drive(0, 0, 0, 0, 1, 16'h0000);
    // Assert reset between edges; it must act without a clock edge.
    @(posedge clk);
    #3;
    reset_n = 1'b0;
    m_reset();
    #1;
    checks++;
    if (out0 !== 16'h0000 || out2 !== 16'h1234 || cnt0 !== 3'd0 || empty0 !== 1'b1) begin
      errors++;
      $display("FAIL async_reset: got out0=%h out2=%h cnt0=%0d empty0=%b, expected 0000 1234 0 1",
               out0, out2, cnt0, empty0);
    end
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  task automatic test_inc();
    logic [15:0] want;
    for (int k = 1; k <= 3; k++) begin
      drive(0, 0, 0, 0, 1, 16'h0000);
      want = 16'(k);
      checks++;
      if (out0 !== want) begin
        errors++;
        $display("FAIL inc_step%0d: got %h, expected %h", k, out0, want);
      end
    end
    drive(0, 1, 0, 0, 0, 16'hFFFF);
    drive(0, 0, 0, 0, 1, 16'h0000);
    checks++;
    if (out0 !== 16'h0000) begin
      errors++;
      $display("FAIL inc_wrap: got %h, expected 0000", out0);
    end
  endtask

  task automatic test_priority();
    drive(0, 1, 0, 0, 0, 16'h0010);
    drive(0, 1, 1, 0, 1, 16'h0200);
    checks++;
    if (out0 !== 16'h0200 || cnt0 !== 3'd0) begin
      errors++;
      $display("FAIL prio_load_over_call: got out=%h cnt=%0d, expected 0200 0", out0, cnt0);
    end
    drive(1, 1, 0, 0, 0, 16'h5555);
    checks++;
    if (out0 !== 16'h0000 || out2 !== 16'h1234) begin
      errors++;
      $display("FAIL prio_clr_over_load: got out0=%h out2=%h, expected 0000 1234", out0, out2);
    end
  endtask

  task automatic test_nested();
    drive(0, 1, 0, 0, 0, 16'h0005);
    drive(0, 0, 1, 0, 0, 16'h0100);
    drive(0, 0, 1, 0, 0, 16'h0200);
    checks++;
    if (cnt0 !== 3'd2 || out0 !== 16'h0200) begin
      errors++;
      $display("FAIL nested_calls: got cnt=%0d out=%h, expected 2 0200", cnt0, out0);
    end
    drive(0, 0, 0, 1, 0, 16'h0000);
    checks++;
    if (out0 !== 16'h0101) begin
      errors++;
      $display("FAIL nested_ret1: got %h, expected 0101", out0);
    end
    drive(0, 0, 0, 1, 0, 16'h0000);
    checks++;
    if (out0 !== 16'h0006 || empty0 !== 1'b1) begin
      errors++;
      $display("FAIL nested_ret2: got out=%h empty=%b, expected 0006 1", out0, empty0);
    end
  endtask

  task automatic test_full();
    logic [15:0] e0 [4];
    logic [15:0] e1 [4];
    e0 = '{16'h0014, 16'h0013, 16'h0012, 16'h0011};
    e1 = '{16'h0015, 16'h0014, 16'h0013, 16'h0012};
    drive(1, 0, 0, 0, 0, 16'h0000);
    drive(0, 1, 0, 0, 0, 16'h0010);
    for (int k = 0; k < 5; k++) drive(0, 0, 1, 0, 0, 16'h0011 + 16'(k));
    checks++;
    if (full0 !== 1'b1 || ovf0 !== 1'b1 || out0 !== 16'h0015 || cnt1 !== 3'd4 || ovf1 !== 1'b1) begin
      errors++;
      $display("FAIL full_state: got full0=%b ovf0=%b out0=%h cnt1=%0d ovf1=%b, expected 1 1 0015 4 1",
               full0, ovf0, out0, cnt1, ovf1);
    end
    for (int k = 0; k < 4; k++) begin
      drive(0, 0, 0, 1, 0, 16'h0000);
      checks++;
      if (out0 !== e0[k] || out1 !== e1[k]) begin
        errors++;
        $display("FAIL full_ret%0d: got drop=%h overwrite=%h, expected %h %h", k, out0, out1, e0[k], e1[k]);
      end
    end
  endtask

  task automatic test_underflow();
    drive(1, 0, 0, 0, 0, 16'h0000);
    drive(0, 1, 0, 0, 0, 16'h0042);
    drive(0, 0, 0, 1, 0, 16'h0000);
    checks++;
    if (out0 !== 16'h0042 || unf0 !== 1'b1) begin
      errors++;
      $display("FAIL underflow_set: got out=%h unf=%b, expected 0042 1", out0, unf0);
    end
    drive(0, 0, 1, 0, 0, 16'h0300);
    drive(0, 0, 0, 1, 0, 16'h0000);
    checks++;
    if (out0 !== 16'h0043 || unf0 !== 1'b1) begin
      errors++;
      $display("FAIL underflow_sticky: got out=%h unf=%b, expected 0043 1", out0, unf0);
    end
    drive(1, 0, 0, 0, 0, 16'h0000);
    checks++;
    if (unf0 !== 1'b0) begin
      errors++;
      $display("FAIL underflow_clr: got %b, expected 0", unf0);
    end
  endtask

  task automatic test_back_to_back();
    logic [15:0] t;
    drive(0, 1, 0, 0, 0, 16'h0A00);
    for (int k = 0; k < 6; k++) begin
      t = 16'($urandom_range(16'hFFFF));
      drive(0, 0, 1, 0, 0, t);
      drive(0, 0, 0, 1, 0, 16'h0000);
      checks++;
      if (out0 !== 16'h0A01) begin
        errors++;
        $display("FAIL b2b_ret%0d: got %h, expected 0a01", k, out0);
      end
      drive(0, 1, 0, 0, 0, 16'h0A00);
    end
  endtask

  task automatic test_random();
    logic r_clr;
    for (int k = 0; k < 400; k++) begin
      r_clr = ($urandom_range(31) == 0);
      drive(r_clr, ($urandom_range(7) == 0), ($urandom_range(2) == 0),
            ($urandom_range(2) == 0), $urandom_range(1), 16'($urandom_range(16'hFFFF)));
    end
  endtask

  initial begin
    test_reset();
    test_inc();
    test_priority();
    test_nested();
    test_full();
    test_underflow();
    test_back_to_back();
    test_random();
    repeat (2) @(posedge clk);
    #3;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: %0d predictions left, expected 0", q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
